ad9866_spi_slave: RTL
=====================

Name: ad9866_spi_slave

Overview:
- Synthesizable SPI responder that emulates the AD9866 4-wire register port. Used as the far end of the on-chip AD9866 SPI initiator in loopback builds and benches.
- Decodes 16-bit frames: bit15 R/W (1 = read), bits14:13 N1N0 byte count, bits12:8 address, bits7:0 data.
- Holds a register file of 20 bytes, returns read data on sdo, and exports decoded RX-power, RX-PGA and TX-gain fields.
- All SPI inputs are synchronous to clk; the initiator lives in the same clock domain.

Parameters:
NUM_REGS, 20, implemented register addresses 0x00..NUM_REGS-1; legal range 1..32.
RST_REG06, 8'h54, reset value of address 0x06; every other register resets to 8'h00.

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous assert, active low
sclk  input  1  SPI clock from initiator; idle low
sen_n  input  1  SPI enable from initiator, active low
sdio  input  1  SPI data from initiator, MSB first
sdo  output  1  SPI read data to initiator
wr_stb  output  1  one-cycle pulse per committed write
wr_addr  output  5  address of the last committed write
wr_data  output  8  data of the last committed write
frame_err  output  1  one-cycle pulse per malformed or aborted frame
rx_pd  output  1  reg 0x01 bit0
rx_pga  output  6  reg 0x09 bits5:0
tx_gain  output  4  reg 0x0a bits3:0
dbg_addr  input  5  debug read address
dbg_data  output  8  register[dbg_addr], combinational; 0 when out of range

Behaviour:
Reset:
- Asserting rst_n low at any time, including mid-frame, immediately returns the block to IDLE.
- All registers take their reset values; bit counter = 0.
- Outputs: sdo = 0, wr_stb = 0, wr_addr = 0, wr_data = 0, frame_err = 0.

Edge detection:
- sclk_q is sclk registered once.
- rise = sclk & ~sclk_q; fall = ~sclk & sclk_q.
- Edges are acted on only while sen_n = 0.
- The initiator runs at 4 clk per sclk period; the block must support 4 clk per period minimum.

Rise handling:
- On a rise, sdio shifts into shreg[15:0] (MSB first) and bitcnt increments (range 0..16).

States:
- IDLE
  - sdo = 0, bitcnt = 0.
  - sen_n falling -> SHIFT.
- SHIFT, at rise 3 (bits 15:13 received):
  - If N1N0 != 00, pulse frame_err -> DRAIN.
- SHIFT, at fall 8 (address complete):
  - If R/W = 1, latch rdata = register[addr] (0 if addr >= NUM_REGS).
  - Drive sdo = rdata[7] from the next cycle.
  - Each later fall shifts rdata left onto sdo, so falls 9..15 present bits 6..0.
  - If R/W = 0, sdo stays 0.
- SHIFT, at rise 16:
  - If R/W = 0 and addr < NUM_REGS: register[addr] <= shreg data byte; wr_addr/wr_data update; wr_stb pulses, all in the cycle after the rise.
  - If R/W = 0 and addr >= NUM_REGS: no register update, no wr_stb, no frame_err.
  - Then -> DRAIN.
- SHIFT, sen_n rises before rise 16:
  - Pulse frame_err, discard the frame with no write -> IDLE.
- DRAIN
  - sdo = 0.
  - Any further rise while sen_n = 0 pulses frame_err once per frame; the completed write stands.
  - sen_n high -> IDLE.

Other rules:
- sen_n falling and a rise in the same cycle: the rise counts as bit 15.
- Register 0x00 is writable but has no side effects.
- Back-to-back frames with sen_n high for 1 clk must decode correctly.
- Outputs rx_pd, rx_pga and tx_gain follow register contents with 0 extra latency after the write commit.

Test Plan:
1. Drive the initiator init sequence (0x06<=54, 0x07<=20, 0x0b<=00, 0x0c<=43, 0x0d<=03, 0x0e<=81, 0x10<=80, 0x11<=00, 0x12<=00) -> 9 wr_stb pulses in order, matching dbg_data readback, frame_err never set.
2. Write 0x0a<=0x45, then read frame 0x8A00 -> tx_gain = 5; initiator captures dataout = 0x45; sdo = 0 outside falls 8..15.
3. Write frame 0x094A -> rx_pga = 0x0A; 0x0101 then 0x0100 -> rx_pd 1 then 0.
4. Frame 0x2B12 (N1N0 = 01) -> frame_err pulse at rise 3; reg 0x0b unchanged; next legal frame accepted.
5. Raise sen_n after 10 bits of 0x0BFF -> frame_err, no wr_stb, reg 0x0b unchanged. Write to 0x15 -> no wr_stb, read of 0x15 returns 0x00.
6. Assert rst_n low mid-frame after a prior write of 0x0b<=0x77 -> reg 0x0b = 0, reg 0x06 = 0x54, all outputs 0; the following full frame decodes correctly.

Source files
------------

// File: rtl/ad9866_spi_slave.sv
// ---------------------------------------------------------------------------
// ad9866_spi_slave
// SPI responder emulating the AD9866 4-wire register port. It is the far end
// of the on-chip AD9866 SPI initiator in loopback builds. Frames are 16 bits,
// MSB first: [15] R/W (1 = read), [14:13] N1N0 byte count (only 00 legal),
// [12:8] address, [7:0] data. All SPI inputs are synchronous to clk.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   sclk       SPI clock from initiator (idle low)
//   sen_n      SPI enable, active low
//   sdio       SPI data from initiator, MSB first
//   sdo        SPI read data to initiator
//   wr_stb     one-cycle pulse per committed write
//   wr_addr    address of the last committed write
//   wr_data    data of the last committed write
//   frame_err  one-cycle pulse per malformed or aborted frame
//   rx_pd      register 0x01 bit 0
//   rx_pga     register 0x09 bits 5:0
//   tx_gain    register 0x0a bits 3:0
//   dbg_addr   debug read address
//   dbg_data   register[dbg_addr], combinational, 0 when unimplemented
// ---------------------------------------------------------------------------
module ad9866_spi_slave #(
    parameter int          NUM_REGS  = 20,
    parameter logic [7:0]  RST_REG06 = 8'h54
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       sen_n,
    input  logic       sdio,
    output logic       sdo,
    output logic       wr_stb,
    output logic [4:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_err,
    output logic       rx_pd,
    output logic [5:0] rx_pga,
    output logic [3:0] tx_gain,
    input  logic [4:0] dbg_addr,
    output logic [7:0] dbg_data
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Six bits hold the full legal range 1..32 for the address comparison.
    localparam logic [5:0] NUM_REGS_L = 6'(NUM_REGS);

    logic [1:0]  state_r;
    logic        sclk_q_r;
    logic        sen_q_r;
    logic [4:0]  bitcnt_r;
    // Bits received so far; the 16th bit is taken straight from sdio.
    logic [14:0] shreg_r;
    // Remaining read bits; bit 7 goes out directly at the address fall.
    logic [6:0]  rdata_r;
    logic        rd_r;
    logic        err_seen_r;

    logic [7:0]  regs_r [NUM_REGS];
    logic [7:0]  regs_pad_s [32];

    logic        rise_s;
    logic        fall_s;
    logic        sen_fall_s;
    logic [15:0] next_shreg_s;
    logic [4:0]  next_cnt_s;
    logic        addr_ok_s;
    logic        wr_en_s;
    logic [7:0]  rd_byte_s;

    // Unimplemented addresses read as zero through a full 32-entry view.
    for (genvar g = 0; g < 32; g++) begin : g_pad
        if (g < NUM_REGS) begin : g_impl
            assign regs_pad_s[g] = regs_r[g];
        end else begin : g_unimpl
            assign regs_pad_s[g] = 8'h00;
        end
    end

    assign rx_pd    = regs_pad_s[1][0];
    assign rx_pga   = regs_pad_s[9][5:0];
    assign tx_gain  = regs_pad_s[10][3:0];
    assign dbg_data = regs_pad_s[dbg_addr];

    // Edge detection, frame field decode and write-commit qualification.
    always_comb begin
        rise_s       = sclk & ~sclk_q_r & ~sen_n;
        fall_s       = ~sclk & sclk_q_r & ~sen_n;
        sen_fall_s   = ~sen_n & sen_q_r;
        next_shreg_s = {shreg_r, sdio};
        next_cnt_s   = bitcnt_r + 5'd1;
        addr_ok_s    = ({1'b0, next_shreg_s[12:8]} < NUM_REGS_L);
        wr_en_s      = (state_r == ST_SHIFT) && rise_s && (next_cnt_s == 5'd16)
                       && !next_shreg_s[15] && addr_ok_s;
        // At the address fall, the address sits in the low five received bits.
        rd_byte_s    = regs_pad_s[shreg_r[4:0]];
    end

    // Register file: reset values and write commit on the 16th rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= (i == 32'd6) ? RST_REG06 : 8'h00;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en_s && (next_shreg_s[12:8] == 5'(i))) begin
                    regs_r[i] <= next_shreg_s[7:0];
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // Frame sequencer: shift, header check, read serialisation, error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            sclk_q_r   <= 1'b0;
            // Cleared so a frame already in progress at reset release is ignored
            // until sen_n is seen high again.
            sen_q_r    <= 1'b0;
            bitcnt_r   <= 5'd0;
            shreg_r    <= 15'd0;
            rdata_r    <= 7'd0;
            rd_r       <= 1'b0;
            err_seen_r <= 1'b0;
            sdo        <= 1'b0;
            wr_stb     <= 1'b0;
            wr_addr    <= 5'd0;
            wr_data    <= 8'd0;
            frame_err  <= 1'b0;
        end else begin
            sclk_q_r  <= sclk;
            sen_q_r   <= sen_n;
            wr_stb    <= 1'b0;
            frame_err <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    sdo        <= 1'b0;
                    rd_r       <= 1'b0;
                    err_seen_r <= 1'b0;
                    if (sen_fall_s) begin
                        state_r <= ST_SHIFT;
                        // A rise coincident with sen_n falling is bit 15.
                        if (rise_s) begin
                            shreg_r  <= next_shreg_s[14:0];
                            bitcnt_r <= next_cnt_s;
                        end else begin
                            bitcnt_r <= 5'd0;
                        end
                    end else begin
                        bitcnt_r <= 5'd0;
                    end
                end
                ST_SHIFT: begin
                    if (sen_n) begin
                        frame_err <= 1'b1;
                        sdo       <= 1'b0;
                        bitcnt_r  <= 5'd0;
                        state_r   <= ST_IDLE;
                    end else if (rise_s) begin
                        shreg_r  <= next_shreg_s[14:0];
                        bitcnt_r <= next_cnt_s;
                        if ((next_cnt_s == 5'd3) && (next_shreg_s[1:0] != 2'b00)) begin
                            frame_err  <= 1'b1;
                            err_seen_r <= 1'b1;
                            sdo        <= 1'b0;
                            state_r    <= ST_DRAIN;
                        end else if (next_cnt_s == 5'd16) begin
                            sdo     <= 1'b0;
                            state_r <= ST_DRAIN;
                            if (wr_en_s) begin
                                wr_stb  <= 1'b1;
                                wr_addr <= next_shreg_s[12:8];
                                wr_data <= next_shreg_s[7:0];
                            end else begin
                                wr_stb <= 1'b0;
                            end
                        end else begin
                            state_r <= ST_SHIFT;
                        end
                    end else if (fall_s && (bitcnt_r == 5'd8)) begin
                        // Address complete: R/W is the eighth bit back.
                        rd_r <= shreg_r[7];
                        if (shreg_r[7]) begin
                            sdo     <= rd_byte_s[7];
                            rdata_r <= rd_byte_s[6:0];
                        end else begin
                            sdo <= 1'b0;
                        end
                    end else if (fall_s && rd_r && (bitcnt_r > 5'd8) && (bitcnt_r < 5'd16)) begin
                        sdo     <= rdata_r[6];
                        rdata_r <= {rdata_r[5:0], 1'b0};
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_DRAIN: begin
                    sdo <= 1'b0;
                    if (sen_n) begin
                        state_r <= ST_IDLE;
                    end else if (rise_s && !err_seen_r) begin
                        // Over-long frame: flag once, the committed write stands.
                        frame_err  <= 1'b1;
                        err_seen_r <= 1'b1;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: begin
                    sdo      <= 1'b0;
                    bitcnt_r <= 5'd0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
